// File: rtl/seg7_scan_driver_pkg.sv
// rtl/seg7_scan_driver_pkg.sv - shared state encoding and segment codes for the 7-segment scan driver
package seg7_pkg;

  typedef enum logic [1:0] {
    S_H = 2'd0,
    S_T = 2'd1,
    S_O = 2'd2
  } state_t;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - digit inputs and display outputs of the scan driver
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic       enable;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       blank_lz;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_done;

  modport master (
    output enable, hundreds, tens, ones, blank_lz,
    input  seg, an, frame_done
  );

  modport slave (
    input  enable, hundreds, tens, ones, blank_lz,
    output seg, an, frame_done
  );

endinterface

// File: rtl/seg7_scan_driver_decoder.sv
// rtl/seg7_scan_driver_decoder.sv - BCD nibble to active-high 7-segment lookup
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 3-digit multiplexed 7-segment driver with per-frame snapshot and blanking
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int COMMON_ANODE = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_N = CNT_W'(BLANK_CYCLES);
  localparam logic             POL     = (COMMON_ANODE != 0);

  logic [CNT_W-1:0] cnt;
  state_t           state;
  logic [3:0]       snap_h, snap_t, snap_o;
  logic             snap_lz;

  logic             tick, take, dark, cur_lz;
  logic [3:0]       cur_h, cur_t, cur_o, digit;
  logic [2:0]       an_raw;
  logic [6:0]       dec_seg, seg_raw;

  seg7_decoder u_decoder (
    .digit (digit),
    .seg   (dec_seg)
  );

  // On the snapshot cycle the live inputs are used so the first slot never shows stale digits.
  always_comb begin
    tick   = (cnt == CNT_MAX);
    take   = (state == S_H) && (cnt == '0);
    cur_h  = take ? bus.hundreds : snap_h;
    cur_t  = take ? bus.tens     : snap_t;
    cur_o  = take ? bus.ones     : snap_o;
    cur_lz = take ? bus.blank_lz : snap_lz;
    digit  = cur_o;
    an_raw = 3'b001;
    dark   = 1'b0;
    case (state)
      S_H: begin
        digit  = cur_h;
        an_raw = 3'b100;
        dark   = cur_lz && (cur_h == 4'd0);
      end
      S_T: begin
        digit  = cur_t;
        an_raw = 3'b010;
        dark   = cur_lz && (cur_h == 4'd0) && (cur_t == 4'd0);
      end
      S_O: begin
        digit  = cur_o;
        an_raw = 3'b001;
      end
      default: begin
        an_raw = 3'b000;
        dark   = 1'b1;
      end
    endcase
    seg_raw = dec_seg;
    if ((cnt < BLANK_N) || dark) begin
      an_raw  = 3'b000;
      seg_raw = SEG_OFF;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt            <= '0;
      state          <= S_H;
      snap_h         <= 4'd0;
      snap_t         <= 4'd0;
      snap_o         <= 4'd0;
      snap_lz        <= 1'b0;
      bus.seg        <= {7{POL}};
      bus.an         <= {3{POL}};
      bus.frame_done <= 1'b0;
    end else if (!bus.enable) begin
      cnt            <= '0;
      state          <= S_H;
      bus.seg        <= {7{POL}};
      bus.an         <= {3{POL}};
      bus.frame_done <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      case (state)
        S_H:     if (tick) state <= S_T;
        S_T:     if (tick) state <= S_O;
        S_O:     if (tick) state <= S_H;
        default: state <= S_H;
      endcase
      if (take) begin
        snap_h  <= bus.hundreds;
        snap_t  <= bus.tens;
        snap_o  <= bus.ones;
        snap_lz <= bus.blank_lz;
      end
      bus.seg        <= seg_raw ^ {7{POL}};
      bus.an         <= an_raw ^ {3{POL}};
      bus.frame_done <= (state == S_O) && tick;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed bench for seg7_scan_driver, common-anode and common-cathode instances
module tb_seg7_scan_driver;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [3:0] hundreds, tens, ones;
  logic       blank_lz;

  int checks = 0;
  int errors = 0;
  int fpos   = 0;

  always #5 clock = ~clock;

  seg7_scan_driver_if ifc_a ();
  seg7_scan_driver_if ifc_c ();

  assign ifc_a.enable   = enable;
  assign ifc_a.hundreds = hundreds;
  assign ifc_a.tens     = tens;
  assign ifc_a.ones     = ones;
  assign ifc_a.blank_lz = blank_lz;
  assign ifc_c.enable   = enable;
  assign ifc_c.hundreds = hundreds;
  assign ifc_c.tens     = tens;
  assign ifc_c.ones     = ones;
  assign ifc_c.blank_lz = blank_lz;

  seg7_scan_driver #(.CLK_DIV(8), .BLANK_CYCLES(1), .COMMON_ANODE(1)) u_ca (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc_a.slave)
  );

  seg7_scan_driver #(.CLK_DIV(8), .BLANK_CYCLES(1), .COMMON_ANODE(0)) u_cc (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc_c.slave)
  );

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_an_a"},  {4'd0, ifc_a.an}, 7'h07);
    chk({tag, "_seg_a"}, ifc_a.seg, 7'h7F);
    chk({tag, "_fd_a"},  {6'd0, ifc_a.frame_done}, 7'h00);
    chk({tag, "_an_c"},  {4'd0, ifc_c.an}, 7'h00);
    chk({tag, "_seg_c"}, ifc_c.seg, 7'h00);
  endtask

  // Codes are common-anode values; lit = {hundreds, tens, ones} not blanked by leading-zero rule.
  task automatic run(input string tag, input int n, input logic [6:0] hc, input logic [6:0] tc,
                     input logic [6:0] oc, input logic [2:0] lit);
    int s, p;
    logic on;
    logic [2:0] oh, ea;
    logic [6:0] code, es;
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      s    = fpos / 8;
      p    = fpos % 8;
      code = (s == 0) ? hc : ((s == 1) ? tc : oc);
      on   = (p != 0) && lit[2-s];
      oh   = 3'b100 >> s;
      ea   = on ? ~oh : 3'b111;
      es   = on ? code : 7'h7F;
      chk($sformatf("%s_an_a@%0d", tag, fpos),  {4'd0, ifc_a.an}, {4'd0, ea});
      chk($sformatf("%s_seg_a@%0d", tag, fpos), ifc_a.seg, es);
      chk($sformatf("%s_fd_a@%0d", tag, fpos),  {6'd0, ifc_a.frame_done}, {6'd0, fpos == 23});
      chk($sformatf("%s_an_c@%0d", tag, fpos),  {4'd0, ifc_c.an}, {4'd0, ~ea});
      chk($sformatf("%s_seg_c@%0d", tag, fpos), ifc_c.seg, ~es);
      fpos = (fpos + 1) % 24;
    end
  endtask

  initial begin
    int last_fd;
    reset_n  = 1'b0;
    enable   = 1'b1;
    hundreds = 4'd2; tens = 4'd5; ones = 4'd5; blank_lz = 1'b0;
    repeat (3) @(posedge clock);
    #1 chk_dark("reset");

    // Basic scan: 2,5,5 for two frames
    reset_n = 1'b1;
    fpos    = 0;
    run("basic", 48, 7'h24, 7'h12, 7'h12, 3'b111);

    // Leading-zero blanking
    hundreds = 4'd0; tens = 4'd0; ones = 4'd7; blank_lz = 1'b1;
    run("lz_on", 24, 7'h40, 7'h40, 7'h78, 3'b001);
    blank_lz = 1'b0;
    run("lz_off", 24, 7'h40, 7'h40, 7'h78, 3'b111);
    hundreds = 4'd0; tens = 4'hF; ones = 4'd0; blank_lz = 1'b1;
    run("lz_dash", 24, 7'h40, 7'h3F, 7'h40, 3'b011);

    // Snapshot stability: inputs change in the middle of the tens slot
    hundreds = 4'd1; tens = 4'd2; ones = 4'd3; blank_lz = 1'b0;
    run("snap_a", 12, 7'h79, 7'h24, 7'h30, 3'b111);
    hundreds = 4'd9; tens = 4'd9; ones = 4'd9;
    run("snap_b", 12, 7'h79, 7'h24, 7'h30, 3'b111);
    run("snap_c", 24, 7'h10, 7'h10, 7'h10, 3'b111);

    // Invalid BCD on tens
    hundreds = 4'd1; tens = 4'hC; ones = 4'd0;
    run("dash", 24, 7'h79, 7'h3F, 7'h40, 3'b111);

    // Enable dropped mid-ones slot, then re-enabled with new digits
    run("pre_en", 20, 7'h79, 7'h3F, 7'h40, 3'b111);
    enable = 1'b0;
    hundreds = 4'd4; tens = 4'd5; ones = 4'd6;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk_dark($sformatf("dis%0d", i));
    end
    enable = 1'b1;
    fpos   = 0;
    run("reen", 24, 7'h19, 7'h12, 7'h02, 3'b111);

    // Asynchronous reset mid-tens slot
    run("pre_rst", 12, 7'h19, 7'h12, 7'h02, 3'b111);
    #2 reset_n = 1'b0;
    #1 chk_dark("async_rst");
    @(posedge clock); #1;
    reset_n = 1'b1;
    fpos    = 0;
    run("post_rst", 24, 7'h19, 7'h12, 7'h02, 3'b111);

    // Random inputs: anode exclusivity and frame spacing
    last_fd = -1;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clock); #1;
      chk("excl_a", {6'd0, $countones(~ifc_a.an) <= 1}, 7'h01);
      chk("excl_c", {6'd0, $countones(ifc_c.an) <= 1}, 7'h01);
      if (ifc_a.frame_done) begin
        if (last_fd >= 0) chk("fd_spacing", 7'(c - last_fd), 7'd24);
        last_fd = c;
      end
      hundreds = 4'($urandom_range(0, 15));
      tens     = 4'($urandom_range(0, 15));
      ones     = 4'($urandom_range(0, 15));
      blank_lz = 1'($urandom_range(0, 1));
    end
    chk("fd_seen", {6'd0, last_fd >= 0}, 7'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
